// File: rtl/sram_axi_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_axi_arbiter_pkg
// Purpose  : Shared types and constants for the two-master AXI-Lite SRAM
//            arbiter: FSM state encoding and AXI response codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sram_axi_arbiter_pkg;

  // Arbiter FSM states; encoding is fixed so the bench and debug tools can
  // decode a raw state value.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage : sram_axi_arbiter_pkg
`default_nettype wire

// File: rtl/sram_axi_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-request round-robin picker. On a tie the requester that did
//            not win last time is chosen; a lone requester always wins.
//            last_grant is updated only when en is high and a request exists.
// Ports    : clk   - clock
//            rst   - synchronous reset, active low (last_grant -> 1)
//            req   - request vector, bit i = master i
//            en    - commit the current pick into last_grant
//            grant - index of the picked master (valid when req != 0)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       grant
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    // Tie: give it to whoever did not win last.
    grant        = ~last_grant_q;
    last_grant_d = last_grant_q;
    if (req == 2'b01) begin
      grant = 1'b0;
    end else if (req == 2'b10) begin
      grant = 1'b1;
    end
    if (en && (req != 2'b00)) begin
      last_grant_d = grant;
    end
  end

  // last_grant resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/sram_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_axi_arbiter
// Purpose  : Shares one AXI-Lite SRAM slave between instruction fetch (m0)
//            and load/store (m1). One complete transaction at a time,
//            round-robin between masters, read before write within a master.
// Ports    : clk, rst         - clock, synchronous active-low reset
//            m0_*/m1_*        - AXI-Lite slave ports facing the two masters
//                               (ar, r, aw, w, b channels)
//            s_*              - AXI-Lite master port facing the SRAM
// Revision : 1.0 - initial release
// ============================================================================
module sram_axi_arbiter
  import sram_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // master 0
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  // master 1
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  // SRAM slave
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready
);

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic [1:0] rd_req, wr_req, req;
  logic       arb_en, arb_grant;

  // The SRAM only accepts AW and W together, so a write needs both.
  assign rd_req = {m1_arvalid, m0_arvalid};
  assign wr_req = {m1_awvalid & m1_wvalid, m0_awvalid & m0_wvalid};
  assign req    = rd_req | wr_req;
  assign arb_en = (state_q == IDLE) && (req != 2'b00);

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .en    (arb_en),
    .grant (arb_grant)
  );

  // Payload buses are muxed by grant; they are only meaningful while the
  // matching valid is high, so they need no state qualification.
  assign s_araddr = grant_q ? m1_araddr : m0_araddr;
  assign s_awaddr = grant_q ? m1_awaddr : m0_awaddr;
  assign s_wdata  = grant_q ? m1_wdata  : m0_wdata;
  assign s_wstrb  = grant_q ? m1_wstrb  : m0_wstrb;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rresp = s_rresp;
  assign m0_bresp = s_bresp;
  assign m1_bresp = s_bresp;

  // Next state and grant.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (arb_en) begin
          grant_d = arb_grant;
          // A master with both pending gets its read serviced first.
          state_d = rd_req[arb_grant] ? RD_ADDR : WR_ADDR;
        end
      end
      RD_ADDR: if (s_arvalid && s_arready) state_d = RD_DATA;
      RD_DATA: if (s_rvalid && s_rready)   state_d = IDLE;
      // W is accepted in the same cycle as AW, so AW alone marks completion.
      WR_ADDR: if (s_awvalid && s_awready) state_d = WR_RESP;
      WR_RESP: if (s_bvalid && s_bready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake routing: everything outside the granted master's active
  // channel is forced low.
  always_comb begin
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_awready = 1'b0;
    m0_wready  = 1'b0;
    m0_bvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    unique case (state_q)
      RD_ADDR: begin
        s_arvalid = grant_q ? m1_arvalid : m0_arvalid;
        if (grant_q) m1_arready = s_arready;
        else         m0_arready = s_arready;
      end
      RD_DATA: begin
        s_rready = grant_q ? m1_rready : m0_rready;
        if (grant_q) m1_rvalid = s_rvalid;
        else         m0_rvalid = s_rvalid;
      end
      WR_ADDR: begin
        s_awvalid = grant_q ? m1_awvalid : m0_awvalid;
        s_wvalid  = grant_q ? m1_wvalid  : m0_wvalid;
        if (grant_q) begin
          m1_awready = s_awready;
          m1_wready  = s_wready;
        end else begin
          m0_awready = s_awready;
          m0_wready  = s_wready;
        end
      end
      WR_RESP: begin
        s_bready = grant_q ? m1_bready : m0_bready;
        if (grant_q) m1_bvalid = s_bvalid;
        else         m0_bvalid = s_bvalid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

endmodule : sram_axi_arbiter
`default_nettype wire

// File: tb/tb_sram_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_axi_arbiter
// Purpose  : Self-checking bench for sram_axi_arbiter. Contains a simple
//            AXI-Lite SRAM slave with random ready, two master drivers and a
//            word-level memory model used for expected read data.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_axi_arbiter;
  import sram_axi_arbiter_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_awvalid, m0_awready;
  logic m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_awvalid, m1_awready;
  logic m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_rresp, s_bresp;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic s_wvalid, s_wready, s_bvalid, s_bready;

  sram_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  // ---------------- SRAM slave model ----------------
  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    if (i == 4) return 32'hDEAD_BEEF;
    return {b, ~b, 8'h5A, b};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  logic [31:0] mem [0:255];
  bit          seeded = 1'b0;
  logic        rdy_q  = 1'b0;
  logic [32:0] slv_log [$];   // {is_write, address} in slave acceptance order

  assign s_arready = rdy_q && !s_rvalid;
  assign s_awready = rdy_q && !s_bvalid && s_awvalid && s_wvalid;
  assign s_wready  = s_awready;

  always @(posedge clk) begin
    rdy_q <= ($urandom_range(0, 3) != 0);
    if (!seeded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      seeded <= 1'b1;
    end
    if (!rst) begin
      s_rvalid <= 1'b0;
      s_bvalid <= 1'b0;
    end else begin
      if (s_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[s_araddr[9:2]];
        s_rresp  <= RESP_OKAY;
        slv_log.push_back({1'b0, s_araddr});
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
      if (s_awvalid && s_awready) begin
        mem[s_awaddr[9:2]] <= merge(mem[s_awaddr[9:2]], s_wdata, s_wstrb);
        s_bvalid <= 1'b1;
        s_bresp  <= RESP_OKAY;
        slv_log.push_back({1'b1, s_awaddr});
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  // ---------------- reference memory and master helpers ----------------
  logic [31:0] ref_mem [0:255];

  function automatic logic [14:0] hs_outs();
    return {m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid,
            m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid,
            s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
  endfunction

  function automatic logic get_arready(input int m); return (m == 0) ? m0_arready : m1_arready; endfunction
  function automatic logic get_rvalid(input int m);  return (m == 0) ? m0_rvalid  : m1_rvalid;  endfunction
  function automatic logic get_awready(input int m); return (m == 0) ? m0_awready : m1_awready; endfunction
  function automatic logic get_wready(input int m);  return (m == 0) ? m0_wready  : m1_wready;  endfunction
  function automatic logic get_bvalid(input int m);  return (m == 0) ? m0_bvalid  : m1_bvalid;  endfunction
  function automatic logic [31:0] get_rdata(input int m); return (m == 0) ? m0_rdata : m1_rdata; endfunction
  function automatic logic [1:0] get_rresp(input int m);  return (m == 0) ? m0_rresp : m1_rresp; endfunction
  function automatic logic [1:0] get_bresp(input int m);  return (m == 0) ? m0_bresp : m1_bresp; endfunction

  task automatic drive_ar(input int m, input logic v, input logic [31:0] a);
    if (m == 0) begin m0_arvalid = v; m0_araddr = a; end
    else        begin m1_arvalid = v; m1_araddr = a; end
  endtask

  task automatic drive_aw(input int m, input logic v, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] st);
    if (m == 0) begin m0_awvalid = v; m0_wvalid = v; m0_awaddr = a; m0_wdata = d; m0_wstrb = st; end
    else        begin m1_awvalid = v; m1_wvalid = v; m1_awaddr = a; m1_wdata = d; m1_wstrb = st; end
  endtask

  task automatic set_rready(input int m, input logic v);
    if (m == 0) m0_rready = v; else m1_rready = v;
  endtask

  task automatic set_bready(input int m, input logic v);
    if (m == 0) m0_bready = v; else m1_bready = v;
  endtask

  task automatic clear_masters();
    drive_ar(0, 1'b0, '0); drive_ar(1, 1'b0, '0);
    drive_aw(0, 1'b0, '0, '0, '0); drive_aw(1, 1'b0, '0, '0, '0);
    set_rready(0, 1'b0); set_rready(1, 1'b0);
    set_bready(0, 1'b0); set_bready(1, 1'b0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    clear_masters();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    slv_log.delete();
  endtask

  // Full read on master m; rready is raised rdly cycles after the AR handshake.
  task automatic axi_read(input int m, input logic [31:0] a, input int rdly,
                          output logic [31:0] d, output logic [1:0] resp);
    bit ok;
    d = 'x; resp = 'x; ok = 1'b0;
    drive_ar(m, 1'b1, a);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (get_arready(m)) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    drive_ar(m, 1'b0, a);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ar_timeout m%0d addr %h got no arready exp arready within 400 cycles", m, a);
      return;
    end
    repeat (rdly) begin @(posedge clk); #1; end
    set_rready(m, 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (get_rvalid(m)) begin ok = 1'b1; d = get_rdata(m); resp = get_rresp(m); break; end
    end
    @(posedge clk); #1;
    set_rready(m, 1'b0);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL r_timeout m%0d addr %h got no rvalid exp rvalid within 400 cycles", m, a);
    end
  endtask

  // Full write on master m; bready is raised bdly cycles after the AW handshake.
  task automatic axi_write(input int m, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] st, input int bdly, output logic [1:0] resp);
    bit ok;
    resp = 'x; ok = 1'b0;
    drive_aw(m, 1'b1, a, d, st);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (get_awready(m)) begin
        ok = 1'b1;
        checks++;
        if (get_wready(m) !== 1'b1) begin
          errors++;
          $display("FAIL w_with_aw m%0d wready got %b exp 1", m, get_wready(m));
        end
        break;
      end
    end
    @(posedge clk); #1;
    drive_aw(m, 1'b0, a, d, st);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL aw_timeout m%0d addr %h got no awready exp awready within 400 cycles", m, a);
      return;
    end
    repeat (bdly) begin @(posedge clk); #1; end
    set_bready(m, 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (get_bvalid(m)) begin ok = 1'b1; resp = get_bresp(m); break; end
    end
    @(posedge clk); #1;
    set_bready(m, 1'b0);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL b_timeout m%0d addr %h got no bvalid exp bvalid within 400 cycles", m, a);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] a0, a1;
    a0 = BASE + 32'h40; a1 = BASE + 32'h44;
    rst = 1'b0;
    drive_ar(0, 1'b1, a0);
    drive_ar(1, 1'b1, a1);
    drive_aw(1, 1'b1, a1, 32'h1, 4'hF);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (hs_outs() !== 15'd0) begin
        errors++;
        $display("FAIL reset_outs got %b exp 0", hs_outs());
      end
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_arvalid !== 1'b1 || s_araddr !== a0) begin
      errors++;
      $display("FAIL reset_first_grant got arvalid %b addr %h exp arvalid 1 addr %h", s_arvalid, s_araddr, a0);
    end
    checks++;
    if (m1_arready !== 1'b0 || m1_awready !== 1'b0) begin
      errors++;
      $display("FAIL reset_m1_stalled got arready %b awready %b exp 0 0", m1_arready, m1_awready);
    end
  endtask

  task automatic test_lone_read();
    logic [31:0] d;
    logic [1:0]  r;
    bit done, seen;
    apply_reset();
    done = 1'b0; seen = 1'b0;
    fork
      begin axi_read(1, BASE + 32'h10, $urandom_range(0, 2), d, r); done = 1'b1; end
      begin
        while (!done) begin
          @(negedge clk);
          if (m0_arready || m0_rvalid || m0_awready || m0_wready || m0_bvalid) seen = 1'b1;
        end
      end
    join
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lone_rdata got %h exp deadbeef", d); end
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL lone_rresp got %b exp 00", r); end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL lone_m0_quiet got activity %b exp 0", seen); end
  endtask

  task automatic test_contention();
    int idx0 [4];
    int idx1 [4];
    logic [31:0] d0 [4];
    logic [31:0] d1 [4];
    logic [32:0] exp_e;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      idx0[k] = $urandom_range(0, 31);
      idx1[k] = 32 + $urandom_range(0, 31);
    end
    fork
      begin
        logic [1:0] r;
        for (int k = 0; k < 4; k++) axi_read(0, BASE + 32'(idx0[k] * 4), $urandom_range(0, 2), d0[k], r);
      end
      begin
        logic [1:0] r;
        for (int k = 0; k < 4; k++) axi_read(1, BASE + 32'(idx1[k] * 4), $urandom_range(0, 2), d1[k], r);
      end
    join
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (d0[k] !== ref_mem[idx0[k]]) begin errors++; $display("FAIL cont_m0_data[%0d] got %h exp %h", k, d0[k], ref_mem[idx0[k]]); end
      checks++;
      if (d1[k] !== ref_mem[idx1[k]]) begin errors++; $display("FAIL cont_m1_data[%0d] got %h exp %h", k, d1[k], ref_mem[idx1[k]]); end
    end
    checks++;
    if (slv_log.size() != 8) begin
      errors++;
      $display("FAIL cont_count got %0d exp 8", slv_log.size());
    end else begin
      // Both masters always pending, fresh reset: strict alternation from m0.
      for (int j = 0; j < 8; j++) begin
        exp_e = (j % 2 == 0) ? {1'b0, BASE + 32'(idx0[j/2] * 4)} : {1'b0, BASE + 32'(idx1[j/2] * 4)};
        checks++;
        if (slv_log[j] !== exp_e) begin errors++; $display("FAIL cont_order[%0d] got %h exp %h", j, slv_log[j], exp_e); end
      end
    end
  endtask

  task automatic test_rd_wr_same();
    logic [31:0] a, old, d;
    logic [1:0]  r, b;
    a = BASE + 32'h20;
    apply_reset();
    old = ref_mem[8];
    fork
      axi_read(1, a, 1, d, r);
      axi_write(1, a, 32'h1234_5678, 4'b0011, 1, b);
    join
    ref_mem[8] = merge(old, 32'h1234_5678, 4'b0011);
    checks++;
    if (d !== old) begin errors++; $display("FAIL rw_read_first_data got %h exp %h", d, old); end
    checks++;
    if (slv_log.size() != 2 || slv_log[0] !== {1'b0, a} || slv_log[1] !== {1'b1, a}) begin
      errors++;
      $display("FAIL rw_order got n=%0d first %h exp read %h then write", slv_log.size(),
               (slv_log.size() > 0) ? slv_log[0] : 33'h0, {1'b0, a});
    end
    checks++;
    if (b !== RESP_OKAY) begin errors++; $display("FAIL rw_bresp got %b exp 00", b); end
    axi_read(1, a, 0, d, r);
    checks++;
    if (d !== {old[31:16], 16'h5678}) begin
      errors++;
      $display("FAIL rw_readback got %h exp %h", d, {old[31:16], 16'h5678});
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  r0, r1;
    int stall, hs_cyc, ar_cyc;
    bit bad;
    a0 = BASE + 32'h50; a1 = BASE + 32'h90;
    stall = 0; hs_cyc = -1; ar_cyc = -100; bad = 1'b0;
    apply_reset();
    fork
      axi_read(0, a0, 5, d0, r0);
      axi_read(1, a1, 0, d1, r1);
      begin
        for (int n = 0; n < 400; n++) begin
          @(negedge clk);
          if (hs_cyc < 0 && s_rvalid && !s_rready) begin
            stall++;
            if (dut.state_q !== RD_DATA || m1_arready !== 1'b0 || s_arvalid !== 1'b0) bad = 1'b1;
          end
          if (hs_cyc < 0 && s_rvalid && s_rready) hs_cyc = cyc;
          if (hs_cyc >= 0 && s_arvalid && s_araddr === a1) begin ar_cyc = cyc; break; end
        end
      end
    join
    checks++;
    if (stall != 5) begin errors++; $display("FAIL bp_stall_cycles got %0d exp 5", stall); end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL bp_held got violation %b exp 0", bad); end
    checks++;
    if (ar_cyc - hs_cyc != 2) begin errors++; $display("FAIL bp_m1_grant_delay got %0d exp 2", ar_cyc - hs_cyc); end
    checks++;
    if (d0 !== ref_mem[20] || d1 !== ref_mem[36]) begin
      errors++;
      $display("FAIL bp_data got %h %h exp %h %h", d0, d1, ref_mem[20], ref_mem[36]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] a, wd, d;
    logic [1:0]  r;
    bit ok;
    a = BASE + 32'h30; wd = $urandom;
    apply_reset();
    drive_aw(0, 1'b1, a, wd, 4'hF);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin @(negedge clk); if (m0_awready) begin ok = 1'b1; break; end end
    @(posedge clk); #1;
    drive_aw(0, 1'b0, a, wd, 4'hF);
    if (ok) ref_mem[12] = wd;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin @(negedge clk); if (s_bvalid) begin ok = 1'b1; break; end end
    checks++;
    if (!ok || dut.state_q !== WR_RESP) begin
      errors++;
      $display("FAIL rmw_in_wr_resp got state %0d bvalid %b exp state %0d", dut.state_q, s_bvalid, WR_RESP);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut.state_q !== IDLE) begin errors++; $display("FAIL rmw_state got %0d exp %0d", dut.state_q, IDLE); end
    checks++;
    if (m0_bvalid !== 1'b0 || hs_outs() !== 15'd0) begin
      errors++;
      $display("FAIL rmw_outs got bvalid %b outs %b exp 0", m0_bvalid, hs_outs());
    end
    rst = 1'b1;
    @(posedge clk); #1;
    axi_read(0, a, 1, d, r);
    checks++;
    if (d !== ref_mem[12]) begin errors++; $display("FAIL rmw_read_after got %h exp %h", d, ref_mem[12]); end
  endtask

  task automatic master_random(input int m, input int nops);
    int idx;
    logic [31:0] a, d, got;
    logic [3:0]  st;
    logic [1:0]  resp;
    for (int k = 0; k < nops; k++) begin
      idx = m * 32 + $urandom_range(0, 31);
      a   = BASE + 32'(idx * 4);
      if ($urandom_range(0, 1) == 1) begin
        d  = $urandom;
        st = 4'($urandom_range(1, 15));
        axi_write(m, a, d, st, $urandom_range(0, 3), resp);
        ref_mem[idx] = merge(ref_mem[idx], d, st);
        checks++;
        if (resp !== RESP_OKAY) begin errors++; $display("FAIL rnd_bresp m%0d got %b exp 00", m, resp); end
      end else begin
        axi_read(m, a, $urandom_range(0, 3), got, resp);
        checks++;
        if (got !== ref_mem[idx] || resp !== RESP_OKAY) begin
          errors++;
          $display("FAIL rnd_read m%0d addr %h got %h/%b exp %h/00", m, a, got, resp, ref_mem[idx]);
        end
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    fork
      master_random(0, 16);
      master_random(1, 16);
    join
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish before 500000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    clear_masters();
    test_reset();
    test_lone_read();
    test_contention();
    test_rd_wr_same();
    test_backpressure();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sram_axi_arbiter
`default_nettype wire
